// File: rtl/mesh_term_src_fifo_pkg.sv
// Shared mesh constants and the packet type used by terminal buffers.
package mesh_pkg;

   localparam int PCKG_SZ    = 40;
   localparam int FIFO_DEPTH = 4;
   localparam int ROWS       = 4;
   localparam int COLUMS     = 4;
   localparam int NUM_TERM   = ROWS*2 + COLUMS*2;

   typedef logic [PCKG_SZ-1:0] pkt_t;

endpackage

// File: rtl/mesh_term_src_fifo_mem.sv
// Register-array packet storage: one synchronous write port, one asynchronous read port.
module mesh_fifo_mem #(
   parameter int width = 40,
   parameter int depth = 4
)(
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(depth)-1:0] waddr,
   input  logic [width-1:0]         wdata,
   input  logic [$clog2(depth)-1:0] raddr,
   output logic [width-1:0]         rdata
);

   logic [width-1:0] mem [depth];

   // Contents are deliberately left unreset; only pointers/count define validity.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mesh_term_src_fifo.sv
// Terminal-side first-word-fall-through source buffer feeding one router port,
// with overflow drop counting and sticky underflow reporting.
module mesh_term_src_fifo
   import mesh_pkg::*;
#(
   parameter int pckg_sz    = PCKG_SZ,
   parameter int fifo_depth = FIFO_DEPTH,
   parameter int CNT_W      = 16
)(
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              wr_en,
   input  logic [pckg_sz-1:0]                wr_data,
   output logic                              full,
   output logic                              almost_full,
   output logic [$clog2(fifo_depth+1)-1:0]   count,
   output logic                              pndng_i_in,
   output logic [pckg_sz-1:0]                data_out_i_in,
   input  logic                              popin,
   output logic [CNT_W-1:0]                  ovf_cnt,
   output logic                              underflow_err,
   input  logic                              clr_err
);

   localparam int CW = $clog2(fifo_depth+1);
   localparam int PW = $clog2(fifo_depth);

   logic [PW-1:0]      rd_ptr;
   logic [PW-1:0]      wr_ptr;
   logic [pckg_sz-1:0] rd_data;
   logic               do_pop;
   logic               do_push;
   logic               drop;
   logic               bad_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(fifo_depth-1)) ? '0 : p + PW'(1);
   endfunction

   // A pop on a full buffer frees the slot, so a same-cycle push is accepted.
   always_comb begin
      do_pop  = popin && (count != '0);
      bad_pop = popin && (count == '0);
      do_push = wr_en && (!full || do_pop);
      drop    = wr_en && !do_push;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Clear wins over a same-cycle drop or illegal pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_cnt       <= '0;
         underflow_err <= 1'b0;
      end else if (clr_err) begin
         ovf_cnt       <= '0;
         underflow_err <= 1'b0;
      end else begin
         if (drop && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + CNT_W'(1);
         if (bad_pop)                 underflow_err <= 1'b1;
      end
   end

   mesh_fifo_mem #(
      .width (pckg_sz),
      .depth (fifo_depth)
   ) u_mem (
      .clk   (clk),
      .we    (do_push),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   assign full          = (count == CW'(fifo_depth));
   assign almost_full   = (count >= CW'(fifo_depth-1));
   assign pndng_i_in    = (count != '0);
   assign data_out_i_in = pndng_i_in ? rd_data : '0;

endmodule

// File: doc/mesh_term_src_fifo.md
Name: mesh_term_src_fifo

Overview:
- Terminal-side source buffer for one mesh terminal: the packet transmitter that feeds a router port.
- A local writer pushes packets into the block. The block presents the head packet to the mesh on pndng_i_in / data_out_i_in, and the router consumes it by pulsing popin.
- One instance per terminal; ROWS*2+COLUMS*2 instances surround the mesh.
- Also tracks occupancy, dropped writes and illegal pops for scoreboarding.

Parameters:
- pckg_sz, 40, packet width in bits.
- fifo_depth, 4, packet entries; any integer >= 2, not required to be a power of two.
- CNT_W, 16, width of the overflow drop counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  local writer pushes wr_data this cycle.
- wr_data  in  pckg_sz  packet to enqueue.
- full  out  1  count == fifo_depth.
- almost_full  out  1  count >= fifo_depth-1.
- count  out  $clog2(fifo_depth+1)  current occupancy.
- pndng_i_in  out  1  a packet is pending toward the mesh (count != 0).
- data_out_i_in  out  pckg_sz  head packet; valid while pndng_i_in=1.
- popin  in  1  router consumes the head this cycle.
- ovf_cnt  out  CNT_W  number of writes dropped while full; saturating.
- underflow_err  out  1  sticky; set on popin while empty.
- clr_err  in  1  synchronous clear of ovf_cnt and underflow_err.

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous-to-clk deassert handled by the system):
  - rd/wr pointers = 0, count = 0, pndng_i_in = 0, full = 0, almost_full = 0, ovf_cnt = 0, underflow_err = 0.
  - data_out_i_in = 0.
  - Storage contents are not reset.
- Output style: first-word-fall-through.
  - data_out_i_in is driven combinationally from mem[rd_ptr].
  - pndng_i_in, full, almost_full are decoded from registered count; no combinational path from wr_en or popin.
- Write latency: a push in cycle N makes pndng_i_in=1 and the data visible in cycle N+1, when the FIFO was empty.
- Pop: popin=1 with count>0 advances rd_ptr at the edge; the next packet or empty status is visible in cycle N+1.
- Pointers wrap from fifo_depth-1 to 0 (explicit compare, not power-of-two masking).
- Simultaneous events, per clock edge:
  - push only, not full: store at wr_ptr, wr_ptr++, count++.
  - pop only, count>0: rd_ptr++, count--.
  - push and pop, 0<count<fifo_depth: both pointers advance, count unchanged.
  - push and pop, count==fifo_depth: pop frees the slot, push accepted, count stays fifo_depth, no drop.
  - push and pop, count==0: pop is illegal. underflow_err<=1; push accepted; count becomes 1.
  - push only, full: data discarded, pointers unchanged, ovf_cnt++ (saturates at all-ones).
  - pop only, count==0: pointers unchanged, underflow_err<=1.
- clr_err=1 clears ovf_cnt and underflow_err that cycle.
  - clr_err has priority over a same-cycle increment or set (the event is lost).
- Reset asserted mid-operation: immediate flush; all pending packets are lost; outputs return to reset values asynchronously.
- popin is assumed to be a single-cycle pulse per packet. Holding popin high pops one packet per cycle.

Decomposition:
- Package mesh_pkg:
  - default constants PCKG_SZ=40, FIFO_DEPTH=4, ROWS=4, COLUMS=4.
  - NUM_TERM = ROWS*2+COLUMS*2.
  - typedef pkt_t = logic [PCKG_SZ-1:0].
- Sub-module mesh_fifo_mem: register-array storage with a write port and an asynchronous read port, parameterised by width and depth.
- Pointer, count and flag logic stay in mesh_term_src_fifo.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release -> pndng_i_in=0, count=0, ovf_cnt=0, underflow_err=0, data_out_i_in=0.
- Single packet: push 40'hA5_0000_1234 at cycle N -> pndng_i_in=1, data_out_i_in=40'hA5_0000_1234 at N+1; popin at N+2 -> pndng_i_in=0 at N+3.
- Fill and overflow (depth 4):
  - push 0x1..0x5 back-to-back -> full=1 after the 4th push, almost_full=1 after the 3rd, ovf_cnt=1.
  - draining then yields 0x1,0x2,0x3,0x4 in order.
- Full with push+pop in the same cycle: with 4 entries, push 0x9 with popin -> count stays 4, ovf_cnt unchanged; drain order is 0x2,0x3,0x4,0x9.
- Underflow and clear:
  - popin on empty -> underflow_err=1 and stays set.
  - clr_err pulse -> underflow_err=0, ovf_cnt=0.
  - popin+wr_en on empty -> underflow_err=1, count=1.
- Wrap and reset mid-stream:
  - 10 push/pop pairs with varying data -> in-order delivery across pointer wrap.
  - Assert reset with 3 entries queued -> pndng_i_in falls to 0 immediately without waiting for a clock edge; count=0 after release.
